// File: rtl/tx_prbs_pkg.sv
// -----------------------------------------------------------------------------
// tx_prbs_pkg
//   Shared types and constants for the TX PRBS word generator.
//   poly_e  : polynomial select encoding (PRBS7/9/15/31)
//   mode_e  : output pattern select encoding
//   taps_t  : (width, tap) pair describing one Fibonacci LFSR polynomial
//   PAT_CLK : clock-like pattern word
//   W_OUT   : bits per TX word
// -----------------------------------------------------------------------------
package tx_prbs_pkg;

    localparam int unsigned W_OUT   = 16;
    localparam logic [15:0] PAT_CLK = 16'hAAAA;

    typedef enum logic [1:0] {
        POLY_PRBS7  = 2'd0,
        POLY_PRBS9  = 2'd1,
        POLY_PRBS15 = 2'd2,
        POLY_PRBS31 = 2'd3
    } poly_e;

    typedef enum logic [1:0] {
        MODE_PRBS     = 2'd0,
        MODE_PRBS_INV = 2'd1,
        MODE_FIX      = 2'd2,
        MODE_CLK      = 2'd3
    } mode_e;

    typedef struct packed {
        logic [4:0] width;
        logic [4:0] tap;
    } taps_t;

    // x^width + x^tap + 1
    function automatic taps_t poly_taps(input poly_e p);
        taps_t t;
        case (p)
            POLY_PRBS7:  t = '{width: 5'd7,  tap: 5'd6};
            POLY_PRBS9:  t = '{width: 5'd9,  tap: 5'd5};
            POLY_PRBS15: t = '{width: 5'd15, tap: 5'd14};
            default:     t = '{width: 5'd31, tap: 5'd28};
        endcase
        return t;
    endfunction

    function automatic logic [4:0] poly_width(input poly_e p);
        taps_t t;
        t = poly_taps(p);
        return t.width;
    endfunction

endpackage

// File: rtl/tx_prbs16_gen_if.sv
// -----------------------------------------------------------------------------
// tx_prbs16_gen_if
//   Control/data bundle between the TX PRBS generator and its user.
//   cke, poly_sel, mode, seed, load, fix_word, inj_err : controls into generator
//   dout, dout_valid                                   : TX word out
//   inj_cnt                                            : injected-error count,
//                                                        present only when
//                                                        TX_PRBS_INJ_CNT_EN is defined
//   modport master : drives controls, observes outputs
//   modport slave  : the generator side
// -----------------------------------------------------------------------------
interface tx_prbs16_gen_if #(
    parameter int unsigned N_PRBS = 31,
    parameter int unsigned W_OUT  = 16
);
    logic              cke;
    logic [1:0]        poly_sel;
    logic [1:0]        mode;
    logic [N_PRBS-1:0] seed;
    logic              load;
    logic [W_OUT-1:0]  fix_word;
    logic              inj_err;
    logic [W_OUT-1:0]  dout;
    logic              dout_valid;
`ifdef TX_PRBS_INJ_CNT_EN
    logic [15:0]       inj_cnt;

    modport master (
        output cke, poly_sel, mode, seed, load, fix_word, inj_err,
        input  dout, dout_valid, inj_cnt
    );
    modport slave (
        input  cke, poly_sel, mode, seed, load, fix_word, inj_err,
        output dout, dout_valid, inj_cnt
    );
`else
    modport master (
        output cke, poly_sel, mode, seed, load, fix_word, inj_err,
        input  dout, dout_valid
    );
    modport slave (
        input  cke, poly_sel, mode, seed, load, fix_word, inj_err,
        output dout, dout_valid
    );
`endif
endinterface

// File: rtl/tx_prbs16_lfsr_adv.sv
// -----------------------------------------------------------------------------
// tx_prbs16_lfsr_adv
//   Combinational W_OUT-step advance of a Fibonacci LFSR.
//   s        in  : current LFSR state (bits at/above the poly width ignored)
//   poly_sel in  : polynomial
//   s_next   out : state after W_OUT steps (bits at/above the poly width are 0)
//   word     out : step outputs, step 0 in word[W_OUT-1], last step in word[0]
// -----------------------------------------------------------------------------
module tx_prbs16_lfsr_adv
    import tx_prbs_pkg::*;
#(
    parameter int unsigned N_PRBS = 31,
    parameter int unsigned W_OUT  = 16
) (
    input  logic [N_PRBS-1:0] s,
    input  poly_e             poly_sel,
    output logic [N_PRBS-1:0] s_next,
    output logic [W_OUT-1:0]  word
);

    taps_t             tp;
    logic [4:0]        msb_idx;
    logic [4:0]        tap_idx;
    logic [N_PRBS-1:0] mask;
    logic [N_PRBS-1:0] st;
    logic              fb;

    always_comb begin
        tp      = poly_taps(poly_sel);
        msb_idx = tp.width - 5'd1;
        tap_idx = tp.tap - 5'd1;
        mask    = ~({N_PRBS{1'b1}} << tp.width);
        st      = s & mask;
        word    = '0;
        fb      = 1'b0;
        // Output bits shift in from the LSB, so step 0 ends up in the MSB.
        for (int unsigned i = 0; i < W_OUT; i++) begin
            fb   = st[msb_idx] ^ st[tap_idx];
            st   = {st[N_PRBS-2:0], fb} & mask;
            word = {word[W_OUT-2:0], fb};
        end
        s_next = st;
    end

endmodule

// File: rtl/tx_prbs16_gen.sv
// -----------------------------------------------------------------------------
// tx_prbs16_gen
//   Parallel PRBS word source for the TX serializer. One W_OUT-bit word per
//   clk; dout[15] is transmitted first.
//   clk  in : word clock
//   rst  in : synchronous, active-high reset
//   bus     : tx_prbs16_gen_if.slave (cke, poly_sel, mode, seed, load,
//             fix_word, inj_err -> dout, dout_valid [, inj_cnt])
//   Optional feature: TX_PRBS_INJ_CNT_EN adds the saturating inj_cnt counter.
// -----------------------------------------------------------------------------
module tx_prbs16_gen
    import tx_prbs_pkg::*;
#(
    parameter int unsigned N_PRBS = 31,
    parameter int unsigned W_OUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    tx_prbs16_gen_if.slave  bus
);

    logic [N_PRBS-1:0] s;
    logic [N_PRBS-1:0] s_adv;
    logic [N_PRBS-1:0] mask;
    logic [N_PRBS-1:0] seed_m;
    logic [N_PRBS-1:0] seed_g;
    logic [W_OUT-1:0]  adv_word;
    logic [W_OUT-1:0]  pat;
    logic [W_OUT-1:0]  dout_q;
    logic              valid_q;
    logic              inj_q;
    logic              pend;
    logic              pend_nx;
    logic              lock;
    logic              upd;
    poly_e             poly;

    assign poly = poly_e'(bus.poly_sel);

    tx_prbs16_lfsr_adv #(
        .N_PRBS (N_PRBS),
        .W_OUT  (W_OUT)
    ) u_adv (
        .s        (s),
        .poly_sel (poly),
        .s_next   (s_adv),
        .word     (adv_word)
    );

    always_comb begin
        mask    = ~({N_PRBS{1'b1}} << poly_width(poly));
        seed_m  = bus.seed & mask;
        seed_g  = (seed_m == '0) ? mask : seed_m;
        lock    = ((s & mask) == '0);
        pend_nx = pend | (bus.inj_err & ~inj_q);
        upd     = ~rst & ~bus.load & ~lock & bus.cke;
        case (mode_e'(bus.mode))
            MODE_PRBS:     pat = adv_word;
            MODE_PRBS_INV: pat = ~adv_word;
            MODE_FIX:      pat = bus.fix_word;
            MODE_CLK:      pat = PAT_CLK;
            default:       pat = PAT_CLK;
        endcase
    end

    // Edge detector runs regardless of cke so an edge during hold is not lost.
    always_ff @(posedge clk) begin
        if (rst) inj_q <= 1'b0;
        else     inj_q <= bus.inj_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= seed_g;
            dout_q  <= '0;
            valid_q <= 1'b0;
            pend    <= 1'b0;
        end else if (bus.load) begin
            s    <= seed_g;
            pend <= pend_nx;
        end else if (lock) begin
            // All-zero state (e.g. after a poly_sel change) would never leave zero.
            s    <= mask;
            pend <= pend_nx;
        end else if (bus.cke) begin
            s       <= s_adv;
            dout_q  <= pat ^ {pend_nx, {(W_OUT-1){1'b0}}};
            valid_q <= 1'b1;
            pend    <= 1'b0;
        end else begin
            pend <= pend_nx;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;

`ifdef TX_PRBS_INJ_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)                                 cnt_q <= '0;
        else if (upd && pend_nx && cnt_q != '1)  cnt_q <= cnt_q + 16'd1;
    end

    assign bus.inj_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tx_prbs16_gen.sv
module tb_tx_prbs16_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_prbs16_gen_if bus ();

    tx_prbs16_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference LFSR, written straight from the polynomial definition.
    logic [30:0] m_s;
    int          m_w;
    int          m_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_load(input logic [1:0] p, input logic [30:0] seed);
        logic [30:0] mk;
        case (p)
            2'd0:    begin m_w = 7;  m_t = 6;  end
            2'd1:    begin m_w = 9;  m_t = 5;  end
            2'd2:    begin m_w = 15; m_t = 14; end
            default: begin m_w = 31; m_t = 28; end
        endcase
        mk  = (m_w == 31) ? 31'h7FFF_FFFF : ((31'd1 << m_w) - 31'd1);
        m_s = seed & mk;
        if (m_s == 31'd0) m_s = mk;
    endtask

    task automatic model_step(output logic [15:0] w);
        logic fb;
        w = 16'h0;
        for (int i = 0; i < 16; i++) begin
            fb  = m_s[m_w-1] ^ m_s[m_t-1];
            m_s = {m_s[29:0], fb};
            m_s[m_w] = 1'b0;
            if (m_w < 31) m_s = m_s & ((31'd1 << m_w) - 31'd1);
            w[15-i] = fb;
        end
    endtask

    task automatic test_reset;
        logic [15:0] e;
        rst = 1'b1; bus.cke = 1'b0; bus.poly_sel = 2'd0; bus.mode = 2'd0;
        bus.seed = 31'h7F; bus.load = 1'b0; bus.fix_word = 16'h0; bus.inj_err = 1'b0;
        repeat (3) tick;
        checks++;
        if (bus.dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
`ifdef TX_PRBS_INJ_CNT_EN
        checks++;
        if (bus.inj_cnt !== 16'h0) begin failures++; $display("FAIL reset_inj_cnt got=%h exp=0000", bus.inj_cnt); end
`endif
        model_load(2'd0, 31'h7F);
        rst = 1'b0; bus.cke = 1'b1;
        tick; model_step(e);
        checks++;
        if (bus.dout !== 16'h020C) begin failures++; $display("FAIL first_word got=%h exp=020c", bus.dout); end
        checks++;
        if (bus.dout_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", bus.dout_valid); end
        tick; model_step(e);
        checks++;
        if (bus.dout !== 16'h28F2) begin failures++; $display("FAIL second_word got=%h exp=28f2", bus.dout); end
    endtask

    task automatic test_prbs7_period;
        logic [15:0] words [254];
        logic [15:0] e;
        int bad;
        for (int i = 0; i < 254; i++) begin
            tick; model_step(e);
            words[i] = bus.dout;
            checks++;
            if (bus.dout !== e) begin
                failures++;
                $display("FAIL prbs7_word[%0d] got=%h exp=%h", i, bus.dout, e);
            end
        end
        bad = 0;
        for (int n = 0; n < 127; n++) if (words[n+127] !== words[n]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL prbs7_period127 mismatching_words=%0d exp=0", bad); end
        bad = 0;
        for (int p = 1; p < 127; p++) begin
            int diff;
            diff = 0;
            for (int n = 0; n + p < 254; n++) if (words[n+p] !== words[n]) diff++;
            if (diff == 0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL prbs7_short_period periods=%0d exp=0", bad); end
    endtask

    task automatic test_seed_zero;
        logic [15:0] e;
        rst = 1'b1; bus.cke = 1'b0; bus.seed = 31'h0; bus.poly_sel = 2'd0;
        tick;
        rst = 1'b0; bus.cke = 1'b1;
        model_load(2'd0, 31'h0);
        tick; model_step(e);
        checks++;
        if (bus.dout !== 16'h020C) begin failures++; $display("FAIL seed_zero got=%h exp=020c", bus.dout); end
    endtask

    task automatic test_hold;
        logic [15:0] e, held;
        int bad;
        repeat (3) begin tick; model_step(e); end
        bus.cke = 1'b0;
        tick;
        held = bus.dout;
        checks++;
        if (held !== e) begin failures++; $display("FAIL hold_entry got=%h exp=%h", held, e); end
        bad = 0;
        repeat (10) begin
            tick;
            if (bus.dout !== e || bus.dout_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL hold_frozen changed_cycles=%0d exp=0", bad); end
        bus.cke = 1'b1;
        tick; model_step(e);
        checks++;
        if (bus.dout !== e) begin failures++; $display("FAIL hold_resume got=%h exp=%h", bus.dout, e); end
    endtask

    task automatic test_modes;
        logic [15:0] e;
        bus.mode = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick; model_step(e);
            checks++;
            if (bus.dout !== 16'hAAAA) begin failures++; $display("FAIL mode_clk[%0d] got=%h exp=aaaa", i, bus.dout); end
        end
        bus.mode = 2'd0;
        tick; model_step(e);
        checks++;
        if (bus.dout !== e) begin failures++; $display("FAIL mode_return got=%h exp=%h", bus.dout, e); end
        bus.mode = 2'd1;
        tick; model_step(e);
        checks++;
        if (bus.dout !== ~e) begin failures++; $display("FAIL mode_inv got=%h exp=%h", bus.dout, ~e); end
        bus.mode = 2'd2; bus.fix_word = 16'h5A3C;
        tick; model_step(e);
        checks++;
        if (bus.dout !== 16'h5A3C) begin failures++; $display("FAIL mode_fix got=%h exp=5a3c", bus.dout); end
        bus.mode = 2'd0;
        tick; model_step(e);
        checks++;
        if (bus.dout !== e) begin failures++; $display("FAIL mode_fix_return got=%h exp=%h", bus.dout, e); end
    endtask

    task automatic test_load;
        logic [15:0] held, e;
        held = bus.dout;
        bus.load = 1'b1; bus.seed = 31'h7F; bus.cke = 1'b1;
        tick;
        bus.load = 1'b0;
        model_load(2'd0, 31'h7F);
        checks++;
        if (bus.dout !== held) begin failures++; $display("FAIL load_hold got=%h exp=%h", bus.dout, held); end
        tick; model_step(e);
        checks++;
        if (bus.dout !== 16'h020C) begin failures++; $display("FAIL load_first got=%h exp=020c", bus.dout); end
    endtask

    task automatic test_inject;
        logic [15:0] e, d, dall;
        int ndiff, at;
        rst = 1'b1; bus.cke = 1'b0; bus.poly_sel = 2'd3; bus.mode = 2'd0;
        bus.seed = 31'h1234_5678; bus.inj_err = 1'b0;
        tick;
        rst = 1'b0; bus.cke = 1'b1;
        model_load(2'd3, 31'h1234_5678);
        ndiff = 0; dall = 16'h0; at = -1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  bus.inj_err = 1'b1;
            if (i == 10) bus.inj_err = 1'b0;
            tick; model_step(e);
            d = bus.dout ^ e;
            if (d != 16'h0) begin ndiff++; dall = dall | d; at = i; end
        end
        checks++;
        if (ndiff != 1) begin failures++; $display("FAIL inj_count_words got=%0d exp=1", ndiff); end
        checks++;
        if (dall !== 16'h8000) begin failures++; $display("FAIL inj_bit got=%h exp=8000", dall); end
        checks++;
        if (at != 5) begin failures++; $display("FAIL inj_word_index got=%0d exp=5", at); end
`ifdef TX_PRBS_INJ_CNT_EN
        checks++;
        if (bus.inj_cnt !== 16'd1) begin failures++; $display("FAIL inj_cnt_one got=%0d exp=1", bus.inj_cnt); end
`endif
        // Two rising edges while held merge into one pending error.
        bus.cke = 1'b0;
        bus.inj_err = 1'b1; tick;
        bus.inj_err = 1'b0; tick;
        bus.inj_err = 1'b1; tick;
        bus.inj_err = 1'b0; tick;
        checks++;
        if (bus.dout !== e) begin failures++; $display("FAIL inj_hold got=%h exp=%h", bus.dout, e); end
        bus.cke = 1'b1;
        tick; model_step(e);
        checks++;
        if (bus.dout !== (e ^ 16'h8000)) begin failures++; $display("FAIL inj_merged got=%h exp=%h", bus.dout, e ^ 16'h8000); end
        tick; model_step(e);
        checks++;
        if (bus.dout !== e) begin failures++; $display("FAIL inj_cleared got=%h exp=%h", bus.dout, e); end
`ifdef TX_PRBS_INJ_CNT_EN
        checks++;
        if (bus.inj_cnt !== 16'd2) begin failures++; $display("FAIL inj_cnt_two got=%0d exp=2", bus.inj_cnt); end
`endif
    endtask

    initial begin
        test_reset;
        test_prbs7_period;
        test_seed_zero;
        test_hold;
        test_modes;
        test_load;
        test_inject;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
